// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: decode-side inputs and execute-side outputs of the ID/EX pipeline register
interface id_ex_stage_reg_if;
  logic        flush_e;
  logic        reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d;
  logic [2:0]  alu_control_d;
  logic [31:0] rd1_d, rd2_d, sign_imm_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, sign_imm_e;
  logic [4:0]  rs_e, rt_e, rd_e;
  logic        mc_stall_d, alu_start_e;
  modport master (
    output flush_e, reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d,
           alu_control_d, rd1_d, rd2_d, sign_imm_d, rs_d, rt_d, rd_d,
    input  reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e,
           alu_control_e, rd1_e, rd2_e, sign_imm_e, rs_e, rt_e, rd_e, mc_stall_d, alu_start_e
  );
  modport slave (
    input  flush_e, reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d,
           alu_control_d, rd1_d, rd2_d, sign_imm_d, rs_d, rt_d, rd_d,
    output reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e,
           alu_control_e, rd1_e, rd2_e, sign_imm_e, rs_e, rt_e, rd_e, mc_stall_d, alu_start_e
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: decode->execute pipeline register; holds ANN/WGHT ops in E for a set cycle count
module id_ex_stage_reg #(
  parameter int ANN_CYCLES  = 4,
  parameter int WGHT_CYCLES = 3
) (
  input logic clk,
  input logic reset,
  id_ex_stage_reg_if.slave bus
);
  localparam logic [2:0] ALU_ANN  = 3'b100;
  localparam logic [2:0] ALU_WGHT = 3'b101;
  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t       w_state;
  logic [4:0]   r_cnt, w_cnt_nxt;
  logic         r_start, w_start_nxt;
  logic [118:0] r_e, w_e_nxt, w_d;
  logic         w_ann, w_wght;
  assign w_d = {bus.reg_write_d, bus.mem_to_reg_d, bus.mem_write_d, bus.alu_src_d, bus.reg_dst_d,
                bus.alu_control_d, bus.rd1_d, bus.rd2_d, bus.sign_imm_d, bus.rs_d, bus.rt_d, bus.rd_d};
  assign w_ann   = bus.alu_control_d == ALU_ANN;
  assign w_wght  = bus.alu_control_d == ALU_WGHT;
  assign w_state = (r_cnt != 5'd0) ? S_BUSY : S_IDLE;
  // BUSY ignores flush: D is stalled, so the hazard unit re-evaluates after release
  always_comb begin
    w_e_nxt     = r_e;
    w_cnt_nxt   = r_cnt - 5'd1;
    w_start_nxt = 1'b0;
    if (w_state == S_IDLE) begin
      w_e_nxt     = bus.flush_e ? '0 : w_d;
      w_cnt_nxt   = bus.flush_e ? 5'd0 : w_ann ? 5'(ANN_CYCLES - 1) : w_wght ? 5'(WGHT_CYCLES - 1) : 5'd0;
      w_start_nxt = !bus.flush_e && (w_ann || w_wght);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e     <= '0;
      r_cnt   <= 5'd0;
      r_start <= 1'b0;
    end else begin
      r_e     <= w_e_nxt;
      r_cnt   <= w_cnt_nxt;
      r_start <= w_start_nxt;
    end
  end
  assign {bus.reg_write_e, bus.mem_to_reg_e, bus.mem_write_e, bus.alu_src_e, bus.reg_dst_e,
          bus.alu_control_e, bus.rd1_e, bus.rd2_e, bus.sign_imm_e, bus.rs_e, bus.rt_e, bus.rd_e} = r_e;
  assign bus.mc_stall_d  = w_state == S_BUSY;
  assign bus.alu_start_e = r_start;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: scoreboard bench; u0 uses ANN=4/WGHT=3, u1 uses ANN=2/WGHT=1
module tb_id_ex_stage_reg;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  id_ex_stage_reg_if b0 ();
  id_ex_stage_reg_if b1 ();
  id_ex_stage_reg u0 (.clk(clk), .reset(reset), .bus(b0));
  id_ex_stage_reg #(.ANN_CYCLES(2), .WGHT_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  logic [118:0] e0, e1, dv, dva;
  assign e0 = {b0.reg_write_e, b0.mem_to_reg_e, b0.mem_write_e, b0.alu_src_e, b0.reg_dst_e,
               b0.alu_control_e, b0.rd1_e, b0.rd2_e, b0.sign_imm_e, b0.rs_e, b0.rt_e, b0.rd_e};
  assign e1 = {b1.reg_write_e, b1.mem_to_reg_e, b1.mem_write_e, b1.alu_src_e, b1.reg_dst_e,
               b1.alu_control_e, b1.rd1_e, b1.rd2_e, b1.sign_imm_e, b1.rs_e, b1.rt_e, b1.rd_e};
  typedef struct {
    bit           u;
    logic [118:0] e;
    logic         st;
    logic         go;
    string        tag;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int fails = 0;
  task automatic setd(input logic [4:0] ctrl, input logic [2:0] alu, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic fl);
    {b0.reg_write_d, b0.mem_to_reg_d, b0.mem_write_d, b0.alu_src_d, b0.reg_dst_d} = ctrl;
    {b1.reg_write_d, b1.mem_to_reg_d, b1.mem_write_d, b1.alu_src_d, b1.reg_dst_d} = ctrl;
    b0.alu_control_d = alu; b1.alu_control_d = alu;
    b0.rd1_d = r1; b1.rd1_d = r1;
    b0.rd2_d = r2; b1.rd2_d = r2;
    b0.sign_imm_d = imm; b1.sign_imm_d = imm;
    b0.rs_d = rs; b1.rs_d = rs;
    b0.rt_d = rt; b1.rt_d = rt;
    b0.rd_d = rd; b1.rd_d = rd;
    b0.flush_e = fl; b1.flush_e = fl;
    dv = {ctrl, alu, r1, r2, imm, rs, rt, rd};
  endtask
  task automatic push(input bit u, input logic [118:0] e, input logic st, input logic go, input string tag);
    exp_t x;
    x.u = u; x.e = e; x.st = st; x.go = go; x.tag = tag;
    q.push_back(x);
  endtask
  task automatic drain();
    exp_t x;
    logic [118:0] ae;
    logic ast, ago;
    while (q.size() > 0) begin
      x = q.pop_front();
      ae  = x.u ? e1 : e0;
      ast = x.u ? b1.mc_stall_d : b0.mc_stall_d;
      ago = x.u ? b1.alu_start_e : b0.alu_start_e;
      checks++;
      assert (ae === x.e) else begin
        fails++;
        $error("FAIL %s/u%0d E obs=%h exp=%h", x.tag, x.u, ae, x.e);
      end
      checks++;
      assert (ast === x.st) else begin
        fails++;
        $error("FAIL %s/u%0d MCStallD obs=%b exp=%b", x.tag, x.u, ast, x.st);
      end
      checks++;
      assert (ago === x.go) else begin
        fails++;
        $error("FAIL %s/u%0d ALUStartE obs=%b exp=%b", x.tag, x.u, ago, x.go);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask
  initial begin
    setd(5'b11111, 3'b011, 32'hdead_beef, 32'hcafe_f00d, 32'h1234_5678, 5'd1, 5'd2, 5'd3, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    push(0, '0, 0, 0, "rst_async"); push(1, '0, 0, 0, "rst_async");
    drain();
    push(0, '0, 0, 0, "rst_hold"); push(1, '0, 0, 0, "rst_hold");
    step();
    reset = 1'b0;
    setd(5'b10000, 3'b000, 32'd5, 32'd3, 32'd0, 5'd0, 5'd0, 5'd7, 1'b0);
    push(0, dv, 0, 0, "add"); push(1, dv, 0, 0, "add");
    step();
    setd(5'b10000, 3'b100, 32'h0000_00a1, 32'h0000_00b2, 32'h0000_00c3, 5'd4, 5'd5, 5'd6, 1'b0);
    dva = dv;
    push(0, dva, 1, 1, "ann_e1"); push(1, dva, 1, 1, "ann_e1");
    step();
    setd(5'b10001, 3'b001, 32'd9, 32'd4, 32'd0, 5'd8, 5'd9, 5'd10, 1'b0);
    push(0, dva, 1, 0, "ann_e2"); push(1, dva, 0, 0, "ann_e2");
    step();
    push(0, dva, 1, 0, "ann_e3"); push(1, dv, 0, 0, "sub_u1");
    step();
    push(0, dva, 0, 0, "ann_e4"); push(1, dv, 0, 0, "sub_u1b");
    step();
    push(0, dv, 0, 0, "sub_e5"); push(1, dv, 0, 0, "sub_u1c");
    step();
    setd(5'b11010, 3'b000, 32'd100, 32'd200, 32'd16, 5'd11, 5'd12, 5'd13, 1'b1);
    push(0, '0, 0, 0, "flush_lw"); push(1, '0, 0, 0, "flush_lw");
    step();
    setd(5'b10000, 3'b101, 32'd1, 32'd2, 32'd3, 5'd1, 5'd2, 5'd3, 1'b1);
    push(0, '0, 0, 0, "flush_wght"); push(1, '0, 0, 0, "flush_wght");
    step();
    setd(5'b10000, 3'b101, 32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 5'd14, 5'd15, 5'd16, 1'b0);
    dva = dv;
    push(0, dva, 1, 1, "wght_e1"); push(1, dva, 0, 1, "wght_n1");
    step();
    setd(5'b10000, 3'b000, 32'd7, 32'd7, 32'd7, 5'd7, 5'd7, 5'd7, 1'b1);
    push(0, dva, 1, 0, "busy_flush_e2"); push(1, '0, 0, 0, "flush_u1");
    step();
    push(0, dva, 0, 0, "busy_flush_e3"); push(1, '0, 0, 0, "flush_u1b");
    step();
    push(0, '0, 0, 0, "flush_after"); push(1, '0, 0, 0, "flush_u1c");
    step();
    setd(5'b10000, 3'b101, 32'h0000_4444, 32'h0000_5555, 32'h0000_6666, 5'd17, 5'd18, 5'd19, 1'b0);
    push(0, dv, 1, 1, "wght2_e1"); push(1, dv, 0, 1, "wght2_n1");
    step();
    setd(5'b01000, 3'b010, 32'd8, 32'd8, 32'd8, 5'd8, 5'd8, 5'd8, 1'b0);
    push(0, e0, 1, 0, "wght2_e2");
    @(posedge clk);
    #1;
    drain();
    #1;
    reset = 1'b1;
    #1;
    push(0, '0, 0, 0, "rst_busy"); push(1, '0, 0, 0, "rst_busy");
    drain();
    @(posedge clk);
    #1;
    reset = 1'b0;
    setd(5'b00110, 3'b110, 32'h0000_0abc, 32'h0000_0def, 32'd42, 5'd20, 5'd21, 5'd22, 1'b0);
    push(0, dv, 0, 0, "illegal110"); push(1, dv, 0, 0, "illegal110");
    step();
    setd(5'b10000, 3'b100, 32'h0000_0101, 32'h0000_0202, 32'h0000_0303, 5'd1, 5'd1, 5'd1, 1'b0);
    dva = dv;
    push(0, dva, 1, 1, "b2b_c1"); push(1, dva, 1, 1, "b2b_c1");
    step();
    setd(5'b10000, 3'b100, 32'h0000_0404, 32'h0000_0505, 32'h0000_0606, 5'd2, 5'd2, 5'd2, 1'b0);
    push(0, dva, 1, 0, "b2b_c2"); push(1, dva, 0, 0, "b2b_c2");
    step();
    push(0, dva, 1, 0, "b2b_c3"); push(1, dv, 1, 1, "b2b_c3");
    step();
    dva = dv;
    setd(5'b10000, 3'b000, 32'd1, 32'd1, 32'd1, 5'd3, 5'd3, 5'd3, 1'b0);
    push(1, dva, 0, 0, "b2b_c4");
    step();
    push(0, dv, 0, 0, "b2b_c5"); push(1, dv, 0, 0, "b2b_c5");
    step();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
